action_input: RTL and testbench
===============================

ACTION_INPUT -- requirements
Module: action_input

Interface
REQ-001 Parameter AMT_W, default 10: chip-amount width; maximum enterable amount is 999.
REQ-002 Clk  in  1  system clock; all state is updated on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 keycode  in  8  current USB HID keycode; 0 means no key is pressed.
REQ-005 player_turn  in  1  high while the local player is allowed to act.
REQ-006 to_call  in  AMT_W  chips required to call; 0 means betting is open.
REQ-007 min_raise  in  AMT_W  minimum legal bet or raise amount.
REQ-008 stack  in  AMT_W  player's remaining chips.
REQ-009 if_BetCheck  out  1  1 = Bet/Check menu, 0 = Raise/Call menu; feeds button_display.
REQ-010 action  out  3  action_t code: NONE, FOLD, CHECK, CALL, BET, RAISE.
REQ-011 amount  out  AMT_W  chip amount attached to action.
REQ-012 action_valid  out  1  action and amount are stable and valid.
REQ-013 action_ready  in  1  game FSM consumes the action.
REQ-014 entry_amt  out  AMT_W  amount currently being typed, for on-screen display.
REQ-015 entry_on  out  1  high while in amount entry.

Function
REQ-016 if_BetCheck SHALL be registered and equal (to_call == 0), sampled every cycle.
REQ-017 A key press event SHALL fire only on a cycle where keycode is nonzero, differs from the previous-cycle keycode, and the previous keycode was 0 (press-after-release).
REQ-018 FSM states SHALL be IDLE, MENU, AMOUNT, ISSUE.
REQ-019 IDLE->MENU when player_turn=1; any state except ISSUE -> IDLE when player_turn=0.
REQ-020 In MENU, F (0x09) SHALL go to ISSUE with FOLD and amount 0.
REQ-021 In MENU, C (0x06) SHALL go to ISSUE with CHECK (amount 0) if if_BetCheck, else CALL with amount = min(to_call, stack).
REQ-022 In MENU, B (0x05) when if_BetCheck, or R (0x15) when not, SHALL go to AMOUNT with entry_amt cleared; the mismatched letter SHALL be ignored.
REQ-023 In AMOUNT, digit keys (0x1E–0x26 = 1–9, 0x27 = 0) SHALL set entry_amt = entry_amt*10 + digit, ignored once 3 digits are held.
REQ-024 In AMOUNT, Backspace (0x2A) SHALL set entry_amt = entry_amt/10; Escape (0x29) SHALL return to MENU.
REQ-025 In AMOUNT, Enter (0x28) SHALL go to ISSUE with amount = min(entry_amt, stack) if that value is >= min_raise or equals stack (all-in); otherwise Enter SHALL be ignored.
REQ-026 ISSUE SHALL assert action_valid the cycle after entry, holding action and amount constant until the action_valid & action_ready cycle, then go to IDLE.
REQ-027 In ISSUE, keys and player_turn SHALL be ignored.
REQ-028 Outside ISSUE: action_valid=0, action=NONE, amount=0.
REQ-029 Keypress-to-action_valid latency SHALL be exactly 2 cycles for F/C.

Reset
REQ-030 Reset SHALL force: state IDLE, if_BetCheck=1, action=NONE, amount=0, action_valid=0, entry_amt=0, entry_on=0, previous keycode=0.
REQ-031 Reset asserted mid-ISSUE SHALL drop action_valid immediately (asynchronously).

Configuration
REQ-032 Macro ACTION_AMOUNT_EN: when defined, amount entry (REQ-022..025) is compiled in.
REQ-033 When ACTION_AMOUNT_EN is undefined, B/R SHALL go straight to ISSUE with amount = min(min_raise, stack); entry_on and entry_amt SHALL be tied to 0.

Structure
REQ-034 action_t enum, HID keycode constants and AMT_W default SHALL live in package poker_types.
REQ-035 The key edge detector SHALL be sub-module key_edge (keycode in, 1-cycle press strobe and code out).

Verification
REQ-036 to_call=0, player_turn=1, press F -> two cycles later action_valid=1, action=FOLD, amount=0; held until action_ready.
REQ-037 to_call=20, stack=15, press C -> CALL, amount=15; if_BetCheck=0.
REQ-038 to_call=0, min_raise=10, stack=500: B, 4, Enter -> Enter ignored; then 0, Enter -> BET 40.
REQ-039 Keycode 0x05 held 5 cycles -> exactly one press event; B,1,2,3,4 -> entry_amt=123; Backspace -> 12.
REQ-040 player_turn drops in AMOUNT -> IDLE, entry_on=0; Reset during ISSUE -> action_valid=0 with no clock edge.

Source files
------------

// File: rtl/action_input_pkg.sv
// rtl/action_input_pkg.sv - shared poker types, HID keycodes and width defaults
// Package poker_types:
//   action_t   - action code reported to the game FSM
//   state_t    - action_input controller states
//   KEY_*      - USB HID keycodes recognised by the controller
//   is_digit / key_digit - map HID digit keycodes (1..9, 0) to values
package poker_types;

    localparam int AMT_W_DEF = 10;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_FOLD  = 3'd1,
        ACT_CHECK = 3'd2,
        ACT_CALL  = 3'd3,
        ACT_BET   = 3'd4,
        ACT_RAISE = 3'd5
    } action_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MENU   = 2'd1,
        ST_AMOUNT = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    localparam logic [7:0] KEY_B     = 8'h05;
    localparam logic [7:0] KEY_C     = 8'h06;
    localparam logic [7:0] KEY_F     = 8'h09;
    localparam logic [7:0] KEY_R     = 8'h15;
    localparam logic [7:0] KEY_1     = 8'h1E;
    localparam logic [7:0] KEY_0     = 8'h27;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

    // HID orders digits 1..9 then 0, so 0x1E..0x27 is one contiguous range.
    function automatic logic is_digit(input logic [7:0] k);
        return (k >= KEY_1) && (k <= KEY_0);
    endfunction

    function automatic logic [3:0] key_digit(input logic [7:0] k);
        logic [7:0] v;
        v = (k == KEY_0) ? 8'd0 : (k - 8'h1D);
        return v[3:0];
    endfunction

endpackage

// File: rtl/action_input_if.sv
// rtl/action_input_if.sv - action handshake between action_input and the game FSM
// Signals:
//   action       - action_t code
//   amount       - chips attached to the action
//   action_valid - action/amount stable and valid
//   action_ready - consumer accepts the action
// Modports: master (action_input drives), slave (game FSM side)
interface action_input_if import poker_types::*; #(
    parameter int AMT_W = AMT_W_DEF
);
    action_t            action;
    logic [AMT_W-1:0]   amount;
    logic               action_valid;
    logic               action_ready;

    modport master (output action, output amount, output action_valid, input action_ready);
    modport slave  (input action, input amount, input action_valid, output action_ready);
endinterface

// File: rtl/action_input_key_edge.sv
// rtl/action_input_key_edge.sv - keyboard press detector (press-after-release)
// Ports:
//   Clk, Reset - clock, asynchronous active-high reset
//   keycode    - current HID keycode, 0 = no key
//   press      - one-cycle strobe on a fresh key press
//   code       - keycode that goes with press
module key_edge (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       press,
    output logic [7:0] code
);
    logic [7:0] prev_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) prev_q <= 8'h00;
        else       prev_q <= keycode;
    end

    // Rolling from one key straight to another is not a press; the
    // keyboard has to go idle first.
    assign press = (keycode != 8'h00) && (keycode != prev_q) && (prev_q == 8'h00);
    assign code  = keycode;
endmodule

// File: rtl/action_input.sv
// rtl/action_input.sv - keyboard-driven poker action selector
// Build option: ACTION_AMOUNT_EN compiles in typed bet/raise amount entry;
// without it B/R issue the minimum raise (capped at the stack) directly.
// Ports:
//   Clk, Reset   - clock, asynchronous active-high reset
//   keycode      - HID keycode, 0 = no key
//   player_turn  - local player may act
//   to_call      - chips to call, 0 = betting open
//   min_raise    - minimum legal bet/raise
//   stack        - player's remaining chips
//   if_BetCheck  - registered (to_call == 0): Bet/Check menu vs Raise/Call
//   entry_amt    - amount being typed
//   entry_on     - amount entry active
//   act          - action/amount/valid/ready handshake (master)
module action_input import poker_types::*; #(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       keycode,
    input  logic             player_turn,
    input  logic [AMT_W-1:0] to_call,
    input  logic [AMT_W-1:0] min_raise,
    input  logic [AMT_W-1:0] stack,
    output logic             if_BetCheck,
    output logic [AMT_W-1:0] entry_amt,
    output logic             entry_on,
    action_input_if.master   act
);
    state_t           state_q, state_d;
    action_t          action_q, action_d;
    logic [AMT_W-1:0] amount_q, amount_d;
    logic             valid_q, valid_d;
    logic             bet_check_q;
    logic             key_press;
    logic [7:0]       key_code;
    logic [AMT_W-1:0] call_amt;

    key_edge u_key_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (key_press),
        .code    (key_code)
    );

    assign call_amt = (to_call < stack) ? to_call : stack;

`ifdef ACTION_AMOUNT_EN
    logic [AMT_W-1:0] entry_amt_q, entry_amt_d;
    logic [1:0]       digits_q, digits_d;
    logic [AMT_W-1:0] entry_cap;

    assign entry_cap = (entry_amt_q < stack) ? entry_amt_q : stack;
    assign entry_amt = entry_amt_q;
    assign entry_on  = (state_q == ST_AMOUNT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            entry_amt_q <= '0;
            digits_q    <= 2'd0;
        end else begin
            entry_amt_q <= entry_amt_d;
            digits_q    <= digits_d;
        end
    end
`else
    logic [AMT_W-1:0] raise_amt;

    assign raise_amt = (min_raise < stack) ? min_raise : stack;
    assign entry_amt = '0;
    assign entry_on  = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            action_q    <= ACT_NONE;
            amount_q    <= '0;
            valid_q     <= 1'b0;
            bet_check_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            action_q    <= action_d;
            amount_q    <= amount_d;
            valid_q     <= valid_d;
            bet_check_q <= (to_call == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        amount_d = amount_q;
        valid_d  = valid_q;
`ifdef ACTION_AMOUNT_EN
        entry_amt_d = entry_amt_q;
        digits_d    = digits_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (player_turn) state_d = ST_MENU;
            end
            ST_MENU: begin
                if (!player_turn) begin
                    state_d = ST_IDLE;
                end else if (key_press) begin
                    case (key_code)
                        KEY_F: begin
                            state_d  = ST_ISSUE;
                            action_d = ACT_FOLD;
                            amount_d = '0;
                        end
                        KEY_C: begin
                            state_d = ST_ISSUE;
                            if (bet_check_q) begin
                                action_d = ACT_CHECK;
                                amount_d = '0;
                            end else begin
                                action_d = ACT_CALL;
                                amount_d = call_amt;
                            end
                        end
                        KEY_B, KEY_R: begin
                            // B only in the Bet menu, R only in the Raise menu.
                            if ((key_code == KEY_B) == bet_check_q) begin
`ifdef ACTION_AMOUNT_EN
                                state_d     = ST_AMOUNT;
                                entry_amt_d = '0;
                                digits_d    = 2'd0;
`else
                                state_d  = ST_ISSUE;
                                action_d = bet_check_q ? ACT_BET : ACT_RAISE;
                                amount_d = raise_amt;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
`ifdef ACTION_AMOUNT_EN
            ST_AMOUNT: begin
                if (!player_turn) begin
                    state_d     = ST_IDLE;
                    entry_amt_d = '0;
                    digits_d    = 2'd0;
                end else if (key_press) begin
                    if (is_digit(key_code)) begin
                        // Three digits cap the entry at 999.
                        if (digits_q != 2'd3) begin
                            entry_amt_d = AMT_W'(entry_amt_q * 10 + key_digit(key_code));
                            digits_d    = digits_q + 2'd1;
                        end
                    end else begin
                        case (key_code)
                            KEY_BKSP: begin
                                entry_amt_d = entry_amt_q / AMT_W'(10);
                                if (digits_q != 2'd0) digits_d = digits_q - 2'd1;
                            end
                            KEY_ESC: begin
                                state_d     = ST_MENU;
                                entry_amt_d = '0;
                                digits_d    = 2'd0;
                            end
                            KEY_ENTER: begin
                                // Short of the minimum is only legal as an all-in.
                                if ((entry_cap >= min_raise) || (entry_cap == stack)) begin
                                    state_d     = ST_ISSUE;
                                    action_d    = bet_check_q ? ACT_BET : ACT_RAISE;
                                    amount_d    = entry_cap;
                                    entry_amt_d = '0;
                                    digits_d    = 2'd0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
`else
            ST_AMOUNT: state_d = ST_IDLE;
`endif
            ST_ISSUE: begin
                // valid rises one cycle after entry; action/amount were
                // loaded on the entry edge and stay put until accepted.
                valid_d = 1'b1;
                if (valid_q && act.action_ready) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b0;
                    action_d = ACT_NONE;
                    amount_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign if_BetCheck      = bet_check_q;
    assign act.action       = action_q;
    assign act.amount       = amount_q;
    assign act.action_valid = valid_q;
endmodule

// File: tb/tb_action_input.sv
// tb/tb_action_input.sv - directed self-checking bench for action_input
module tb_action_input;
    import poker_types::*;

    localparam int AMT_W = 10;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [7:0]       keycode;
    logic             player_turn;
    logic [AMT_W-1:0] to_call, min_raise, stack;
    logic             if_BetCheck;
    logic [AMT_W-1:0] entry_amt;
    logic             entry_on;

    int errors = 0;
    int checks = 0;

    action_input_if #(.AMT_W(AMT_W)) act_if ();

    action_input #(.AMT_W(AMT_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .player_turn (player_turn),
        .to_call     (to_call),
        .min_raise   (min_raise),
        .stack       (stack),
        .if_BetCheck (if_BetCheck),
        .entry_amt   (entry_amt),
        .entry_on    (entry_on),
        .act         (act_if)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One idle cycle, one press cycle, then release.
    task automatic tap(input logic [7:0] k);
        keycode = 8'h00;
        step();
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic take(input string tag, input logic [2:0] a, input logic [31:0] amt);
        int n;
        n = 0;
        while (!act_if.action_valid && n < 8) begin
            step();
            n++;
        end
        check({tag, " valid"}, 32'(act_if.action_valid), 1);
        check({tag, " action"}, 32'(act_if.action), 32'(a));
        check({tag, " amount"}, 32'(act_if.amount), amt);
        act_if.action_ready = 1'b1;
        step();
        act_if.action_ready = 1'b0;
        check({tag, " released"}, 32'(act_if.action_valid), 0);
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        player_turn = 1'b0;
        to_call = 10'd20;
        min_raise = 10'd10;
        stack = 10'd500;
        act_if.action_ready = 1'b0;
        step(2);
        check("rst valid", 32'(act_if.action_valid), 0);
        check("rst action", 32'(act_if.action), 32'(ACT_NONE));
        check("rst amount", 32'(act_if.amount), 0);
        check("rst betcheck", 32'(if_BetCheck), 1);
        check("rst entry_on", 32'(entry_on), 0);
        check("rst entry_amt", 32'(entry_amt), 0);
        to_call = 10'd0;
        Reset = 1'b0;
        player_turn = 1'b1;
        step(2);

        // Fold: exact two-cycle latency, held through ready low and ignored inputs
        keycode = KEY_F;
        step();
        check("fold latency early", 32'(act_if.action_valid), 0);
        keycode = 8'h00;
        step();
        check("fold valid", 32'(act_if.action_valid), 1);
        check("fold action", 32'(act_if.action), 32'(ACT_FOLD));
        check("fold amount", 32'(act_if.amount), 0);
        player_turn = 1'b0;
        keycode = KEY_C;
        step();
        keycode = 8'h00;
        step(2);
        check("fold hold valid", 32'(act_if.action_valid), 1);
        check("fold hold action", 32'(act_if.action), 32'(ACT_FOLD));
        player_turn = 1'b1;
        act_if.action_ready = 1'b1;
        step();
        act_if.action_ready = 1'b0;
        check("fold done valid", 32'(act_if.action_valid), 0);
        check("fold done action", 32'(act_if.action), 32'(ACT_NONE));

        tap(KEY_C);
        take("check", ACT_CHECK, 0);

        to_call = 10'd20;
        stack = 10'd15;
        step();
        check("raise menu", 32'(if_BetCheck), 0);
        tap(KEY_C);
        take("call capped", ACT_CALL, 15);
        stack = 10'd500;
        tap(KEY_C);
        take("call", ACT_CALL, 20);

        tap(KEY_B);
        step(2);
        check("B in raise menu", 32'(act_if.action_valid), 0);
        check("B in raise menu entry", 32'(entry_on), 0);

`ifdef ACTION_AMOUNT_EN
        tap(KEY_R);
        check("R entry_on", 32'(entry_on), 1);
        tap(8'h22);
        tap(KEY_0);
        check("R entry 50", 32'(entry_amt), 50);
        tap(KEY_ENTER);
        take("raise 50", ACT_RAISE, 50);

        to_call = 10'd0;
        step();
        tap(KEY_R);
        check("R in bet menu", 32'(entry_on), 0);
        tap(KEY_B);
        check("B entry_on", 32'(entry_on), 1);
        check("B entry cleared", 32'(entry_amt), 0);
        tap(8'h21);
        check("entry 4", 32'(entry_amt), 4);
        tap(KEY_ENTER);
        step(2);
        check("enter below min", 32'(act_if.action_valid), 0);
        check("enter below min stays", 32'(entry_on), 1);
        tap(KEY_0);
        check("entry 40", 32'(entry_amt), 40);
        tap(KEY_ENTER);
        take("bet 40", ACT_BET, 40);

        tap(KEY_B);
        tap(8'h1E);
        tap(8'h1F);
        tap(8'h20);
        tap(8'h21);
        check("three digit cap", 32'(entry_amt), 123);
        tap(KEY_BKSP);
        check("backspace", 32'(entry_amt), 12);
        tap(KEY_ESC);
        check("escape", 32'(entry_on), 0);
        tap(KEY_B);
        check("reenter cleared", 32'(entry_amt), 0);
        player_turn = 1'b0;
        step();
        check("turn drop entry_on", 32'(entry_on), 0);
        player_turn = 1'b1;
        step();

        stack = 10'd15;
        min_raise = 10'd100;
        tap(KEY_B);
        tap(8'h22);
        tap(KEY_0);
        tap(KEY_ENTER);
        take("all in", ACT_BET, 15);
        stack = 10'd500;
        min_raise = 10'd10;
`else
        tap(KEY_R);
        take("raise min", ACT_RAISE, 10);
        min_raise = 10'd40;
        stack = 10'd30;
        tap(KEY_R);
        take("raise capped", ACT_RAISE, 30);
        check("entry_on tied", 32'(entry_on), 0);
        check("entry_amt tied", 32'(entry_amt), 0);
        stack = 10'd500;
        to_call = 10'd0;
        step();
        tap(KEY_R);
        step(2);
        check("R in bet menu", 32'(act_if.action_valid), 0);
        tap(KEY_B);
        take("bet min", ACT_BET, 40);
        min_raise = 10'd10;
`endif

        // Held key yields exactly one action
        to_call = 10'd0;
        step();
        keycode = KEY_F;
        step(5);
        check("held valid", 32'(act_if.action_valid), 1);
        check("held action", 32'(act_if.action), 32'(ACT_FOLD));
        act_if.action_ready = 1'b1;
        step();
        act_if.action_ready = 1'b0;
        step(5);
        check("held no repeat", 32'(act_if.action_valid), 0);
        keycode = 8'h00;

        player_turn = 1'b0;
        step();
        tap(KEY_F);
        step(3);
        check("no turn no action", 32'(act_if.action_valid), 0);
        player_turn = 1'b1;
        step();

        // Asynchronous reset while an action is pending
        tap(KEY_F);
        check("pre-reset valid", 32'(act_if.action_valid), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset valid", 32'(act_if.action_valid), 0);
        check("async reset action", 32'(act_if.action), 32'(ACT_NONE));
        step();
        Reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
